// File: rtl/mem_arbiter.sv
// Arbitrates the single memory bus between instruction fetch (I) and data (D) requesters,
// translating kseg0/kseg1 virtual addresses and sequencing one single-beat transaction at a time.
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_valid,
    input  logic [31:0] i_addr,
    output logic        i_addr_ok,
    output logic        i_data_ok,
    output logic [31:0] i_rdata,
    input  logic        d_valid,
    input  logic [31:0] d_addr,
    input  logic        d_write,
    input  logic [1:0]  d_size,
    input  logic [3:0]  d_strobe,
    input  logic [31:0] d_wdata,
    output logic        d_addr_ok,
    output logic        d_data_ok,
    output logic [31:0] d_rdata,
    output logic        m_valid,
    output logic [31:0] m_paddr,
    output logic        m_write,
    output logic [1:0]  m_size,
    output logic [3:0]  m_strobe,
    output logic [31:0] m_wdata,
    output logic        m_uncached,
    input  logic        m_ready,
    input  logic        m_data_ok,
    input  logic [31:0] m_rdata
);

    localparam int unsigned CNT_W = 4;
    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   starve_cnt, starve_next;
    logic               owner;
    logic [31:0]        paddr_q, wdata_q;
    logic               write_q, uncached_q;
    logic [1:0]         size_q;
    logic [3:0]         strobe_q;
    logic               grant_i, grant_d, done;

    // kseg0/kseg1 fold onto physical 0x0000_0000..0x1FFF_FFFF; everything else is identity
    function automatic logic [31:0] to_paddr(input logic [31:0] vaddr);
        logic [3:0] seg;
        case (vaddr[31:28])
            4'h8, 4'hA: seg = 4'h0;
            4'h9, 4'hB: seg = 4'h1;
            default:    seg = vaddr[31:28];
        endcase
        return {seg, vaddr[27:0]};
    endfunction

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            starve_cnt <= '0;
            owner      <= OWNER_I;
            paddr_q    <= '0;
            wdata_q    <= '0;
            write_q    <= 1'b0;
            uncached_q <= 1'b0;
            size_q     <= '0;
            strobe_q   <= '0;
        end else begin
            state      <= state_next;
            starve_cnt <= starve_next;
            if (grant_i) begin
                owner      <= OWNER_I;
                paddr_q    <= to_paddr(i_addr);
                uncached_q <= (i_addr[31:29] == 3'b101);
                write_q    <= 1'b0;
                size_q     <= 2'd2;
                strobe_q   <= '0;
                wdata_q    <= '0;
            end else if (grant_d) begin
                owner      <= OWNER_D;
                paddr_q    <= to_paddr(d_addr);
                uncached_q <= (d_addr[31:29] == 3'b101);
                write_q    <= d_write;
                size_q     <= d_size;
                strobe_q   <= d_write ? d_strobe : 4'd0;
                wdata_q    <= d_wdata;
            end
        end
    end

    always_comb begin
        state_next  = state;
        starve_next = starve_cnt;
        grant_i     = 1'b0;
        grant_d     = 1'b0;
        done        = 1'b0;
        case (state)
            IDLE: begin
                if (i_valid && d_valid) begin
                    if (starve_cnt == CNT_W'(STARVE_LIMIT)) grant_i = 1'b1;
                    else                                    grant_d = 1'b1;
                end else if (i_valid) begin
                    grant_i = 1'b1;
                end else if (d_valid) begin
                    grant_d = 1'b1;
                end
                // counts rounds I has lost in a row while it was waiting
                if (grant_d && i_valid)       starve_next = starve_cnt + CNT_W'(1);
                else if (grant_i || !i_valid) starve_next = '0;
                if (grant_i || grant_d) state_next = REQ;
            end
            REQ: begin
                if (m_ready) begin
                    if (m_data_ok) begin
                        done       = 1'b1;
                        state_next = IDLE;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (m_data_ok) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // everything is forced low while reset is held, including the combinational handshakes
    assign i_addr_ok  = resetn && grant_i;
    assign d_addr_ok  = resetn && grant_d;
    assign i_data_ok  = resetn && done && (owner == OWNER_I);
    assign d_data_ok  = resetn && done && (owner == OWNER_D);
    assign i_rdata    = (resetn && state != IDLE && owner == OWNER_I) ? m_rdata : 32'd0;
    assign d_rdata    = (resetn && state != IDLE && owner == OWNER_D) ? m_rdata : 32'd0;
    assign m_valid    = resetn && (state == REQ);
    assign m_paddr    = resetn ? paddr_q : 32'd0;
    assign m_write    = resetn && write_q;
    assign m_size     = resetn ? size_q : 2'd0;
    assign m_strobe   = resetn ? strobe_q : 4'd0;
    assign m_wdata    = resetn ? wdata_q : 32'd0;
    assign m_uncached = resetn && uncached_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by random traffic, all checked
// against a transaction-level model of arbitration, translation and completion.
module tb_mem_arbiter;

    localparam int unsigned LIMIT = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic        i_valid, i_addr_ok, i_data_ok;
    logic [31:0] i_addr, i_rdata;
    logic        d_valid, d_write, d_addr_ok, d_data_ok;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [1:0]  d_size;
    logic [3:0]  d_strobe;
    logic        m_valid, m_write, m_uncached, m_ready, m_data_ok;
    logic [31:0] m_paddr, m_wdata, m_rdata;
    logic [1:0]  m_size;
    logic [3:0]  m_strobe;

    int total = 0;
    int bad   = 0;

    mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .resetn(resetn),
        .i_valid(i_valid), .i_addr(i_addr), .i_addr_ok(i_addr_ok),
        .i_data_ok(i_data_ok), .i_rdata(i_rdata),
        .d_valid(d_valid), .d_addr(d_addr), .d_write(d_write), .d_size(d_size),
        .d_strobe(d_strobe), .d_wdata(d_wdata), .d_addr_ok(d_addr_ok),
        .d_data_ok(d_data_ok), .d_rdata(d_rdata),
        .m_valid(m_valid), .m_paddr(m_paddr), .m_write(m_write), .m_size(m_size),
        .m_strobe(m_strobe), .m_wdata(m_wdata), .m_uncached(m_uncached),
        .m_ready(m_ready), .m_data_ok(m_data_ok), .m_rdata(m_rdata)
    );

    initial forever #5 clk = ~clk;

    // model: one open transaction at most, either still shown on the bus or awaiting data
    bit          open_txn, shown, own_d, chk_wdata, seen_i, seen_d;
    int unsigned losses;
    logic [31:0] e_paddr, e_wdata;
    logic        e_write, e_unc;
    logic [1:0]  e_size;
    logic [3:0]  e_strobe;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] xlat(input logic [31:0] v);
        if (v >= 32'h8000_0000 && v < 32'hC000_0000) return v & 32'h1FFF_FFFF;
        return v;
    endfunction

    function automatic logic in_kseg1(input logic [31:0] v);
        return (v >= 32'hA000_0000) && (v < 32'hC000_0000);
    endfunction

    task automatic eval_cycle();
        bit wi, wd, fin;
        seen_i = i_addr_ok;
        seen_d = d_addr_ok;
        if (!resetn) begin
            chk32("rst_ctrl", 32'({i_addr_ok, i_data_ok, d_addr_ok, d_data_ok, m_valid,
                                   m_write, m_uncached, m_size, m_strobe}), 32'd0);
            chk32("rst_data", i_rdata | d_rdata | m_paddr | m_wdata, 32'd0);
            open_txn = 0;
            shown    = 0;
            losses   = 0;
            return;
        end
        if (!open_txn) begin
            wi = i_valid && (!d_valid || losses == LIMIT);
            wd = d_valid && !wi;
            chk1("i_addr_ok", i_addr_ok, wi);
            chk1("d_addr_ok", d_addr_ok, wd);
            chk1("idle_m_valid", m_valid, 1'b0);
            chk32("idle_data_ok", 32'({i_data_ok, d_data_ok}), 32'd0);
            if (wd && i_valid)       losses++;
            else if (wi || !i_valid) losses = 0;
            if (wi || wd) begin
                open_txn = 1;
                shown    = 1;
                own_d    = wd;
                if (wi) begin
                    e_paddr = xlat(i_addr); e_unc = in_kseg1(i_addr);
                    e_write = 0; e_size = 2'd2; e_strobe = 4'd0; e_wdata = 32'd0;
                    chk_wdata = 1;
                end else begin
                    e_paddr = xlat(d_addr); e_unc = in_kseg1(d_addr);
                    e_write = d_write; e_size = d_size;
                    e_strobe = d_write ? d_strobe : 4'd0; e_wdata = d_wdata;
                    chk_wdata = d_write;
                end
            end
        end else begin
            chk1("m_valid", m_valid, shown);
            if (shown) begin
                chk32("m_paddr", m_paddr, e_paddr);
                chk1("m_uncached", m_uncached, e_unc);
                chk1("m_write", m_write, e_write);
                chk32("m_size", 32'(m_size), 32'(e_size));
                chk32("m_strobe", 32'(m_strobe), 32'(e_strobe));
                if (chk_wdata) chk32("m_wdata", m_wdata, e_wdata);
            end
            fin = m_data_ok && (!shown || m_ready);
            chk1("i_data_ok", i_data_ok, fin && !own_d);
            chk1("d_data_ok", d_data_ok, fin && own_d);
            chk32("busy_addr_ok", 32'({i_addr_ok, d_addr_ok}), 32'd0);
            if (own_d) begin
                chk32("i_rdata_nonowner", i_rdata, 32'd0);
                if (fin) chk32("d_rdata", d_rdata, m_rdata);
            end else begin
                chk32("d_rdata_nonowner", d_rdata, 32'd0);
                if (fin) chk32("i_rdata", i_rdata, m_rdata);
            end
            if (fin)                  open_txn = 0;
            else if (shown && m_ready) shown = 0;
        end
    endtask

    // inputs are driven 1ns after the rising edge; checks happen 1ns later
    task automatic cycle();
        #1;
        eval_cycle();
        @(posedge clk);
        #1;
        if (seen_i) i_valid = 1'b0;
        if (seen_d) d_valid = 1'b0;
    endtask

    initial begin
        string order;
        resetn = 0; i_valid = 0; i_addr = '0; d_valid = 0; d_addr = '0; d_write = 0;
        d_size = '0; d_strobe = '0; d_wdata = '0; m_ready = 0; m_data_ok = 0; m_rdata = '0;
        @(posedge clk); #1;
        cycle(); cycle();
        resetn = 1;
        cycle();

        // D-only read from kseg1
        d_valid = 1; d_addr = 32'hBFC0_0010; d_write = 0; d_size = 2'd2; d_strobe = 4'hF;
        d_wdata = $urandom();
        #1 chk1("t_d_addr_ok", d_addr_ok, 1'b1);
        cycle();
        #1 chk1("t_d_m_valid", m_valid, 1'b1);
        chk32("t_d_paddr", m_paddr, 32'h1FC0_0010);
        chk1("t_d_unc", m_uncached, 1'b1);
        m_ready = 1;
        cycle();
        m_ready = 0;
        cycle(); cycle();
        m_data_ok = 1; m_rdata = 32'hDEAD_BEEF;
        #1 chk1("t_d_data_ok", d_data_ok, 1'b1);
        chk32("t_d_rdata", d_rdata, 32'hDEAD_BEEF);
        cycle();
        m_data_ok = 0;

        // I-only: kseg0 then useg
        i_valid = 1; i_addr = 32'h8000_0100;
        cycle();
        #1 chk32("t_i_paddr0", m_paddr, 32'h0000_0100);
        chk32("t_i_attr", 32'({m_uncached, m_write, m_size}), 32'd2);
        m_ready = 1; m_data_ok = 1; m_rdata = $urandom();
        cycle();
        m_ready = 0; m_data_ok = 0;
        i_valid = 1; i_addr = 32'h0040_0000;
        cycle();
        #1 chk32("t_i_paddr1", m_paddr, 32'h0040_0000);
        m_ready = 1; m_data_ok = 1; m_rdata = $urandom();
        cycle();
        m_ready = 0; m_data_ok = 0;

        // both requesters held continuously
        order = "";
        m_ready = 1; m_data_ok = 1;
        repeat (12) begin
            if (!i_valid) begin i_valid = 1; i_addr = $urandom(); end
            if (!d_valid) begin
                d_valid = 1; d_addr = $urandom(); d_write = 1'($urandom_range(0, 1));
                d_size = 2'($urandom_range(0, 2)); d_strobe = 4'($urandom()); d_wdata = $urandom();
            end
            m_rdata = $urandom();
            cycle();
            if (seen_i)      order = {order, "I"};
            else if (seen_d) order = {order, "D"};
        end
        total++;
        assert (order == "DDDDID") else begin
            bad++;
            $error("FAIL grant_order observed=%s expected=DDDDID", order);
        end
        i_valid = 0; d_valid = 0; m_ready = 0; m_data_ok = 0;
        cycle();

        // D write accepted and completed in the same cycle, then an immediate re-grant
        d_valid = 1; d_addr = 32'h0000_2000; d_write = 1; d_size = 2'd1;
        d_strobe = 4'b0011; d_wdata = 32'h0000_1234;
        cycle();
        m_ready = 1; m_data_ok = 1; m_rdata = $urandom();
        #1 chk32("t_w_strobe", 32'(m_strobe), 32'h3);
        chk32("t_w_wdata", m_wdata, 32'h0000_1234);
        chk1("t_w_data_ok", d_data_ok, 1'b1);
        cycle();
        m_ready = 0; m_data_ok = 0;
        d_valid = 1; d_write = 0; d_addr = 32'h9000_0004;
        #1 chk1("t_w_regrant", d_addr_ok, 1'b1);
        cycle();
        m_ready = 1; m_data_ok = 1;
        cycle();
        m_ready = 0; m_data_ok = 0;

        // reset while waiting for data; the late response must be dropped
        d_valid = 1; d_addr = 32'hA000_0040; d_write = 0; d_size = 2'd2;
        cycle();
        m_ready = 1;
        cycle();
        m_ready = 0;
        cycle();
        resetn = 0;
        cycle(); cycle();
        resetn = 1; m_data_ok = 1; m_rdata = 32'h5555_AAAA;
        #1 chk32("t_rst_stray", 32'({i_data_ok, d_data_ok, m_valid}), 32'd0);
        cycle();
        m_data_ok = 0;

        // stray response while idle
        m_data_ok = 1;
        #1 chk32("t_idle_stray", 32'({i_data_ok, d_data_ok, m_valid}), 32'd0);
        cycle();
        m_data_ok = 0;

        // random traffic
        repeat (500) begin
            if (!i_valid && $urandom_range(0, 2) == 0) begin i_valid = 1; i_addr = $urandom(); end
            if (!d_valid && $urandom_range(0, 2) == 0) begin
                d_valid = 1; d_addr = $urandom(); d_write = 1'($urandom_range(0, 1));
                d_size = 2'($urandom_range(0, 2)); d_strobe = 4'($urandom()); d_wdata = $urandom();
            end
            m_ready   = 1'($urandom_range(0, 1));
            m_data_ok = ($urandom_range(0, 2) == 0);
            m_rdata   = $urandom();
            resetn    = ($urandom_range(0, 99) != 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
